// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one spi_master between NUM_REQ requesters.
// Each request is latched into the master's TxData/Mode one cycle before a
// one-cycle Start pulse. The result is returned as a one-cycle Ack, or as an
// Err if Done never arrives.
`timescale 1ns/1ps
module spi_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqTxData,
  input  logic [NUM_REQ*2-1:0]          ReqMode,
  output logic [NUM_REQ-1:0]            Grant,
  output logic [NUM_REQ-1:0]            Ack,
  output logic [NUM_REQ-1:0]            Err,
  output logic [DATA_WIDTH-1:0]         RxData,
  output logic                          Busy,
  output logic                          MStart,
  output logic [1:0]                    MMode,
  output logic [DATA_WIDTH-1:0]         MTxData,
  input  logic                          MDone,
  input  logic [DATA_WIDTH-1:0]         MRxData,
  output logic [2:0]                    dbg_state
);

  // Handshake: a requester raises Req[i] and holds it until Ack[i] or Err[i]
  // pulses for one cycle. Grant[i] marks the owner from SETUP through RESP.
  // Dropping Req before Grant withdraws the request. Dropping it after
  // Grant is ignored and the transfer still completes. Toward the master,
  // MStart is a one-cycle pulse, and completion is a rising MDone observed
  // only after MDone has first been seen low.

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_START     = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [NUM_REQ-1:0]      err_q, err_d;
  logic [DATA_WIDTH-1:0]   rx_q, rx_d;
  logic                    busy_q, busy_d;
  logic                    mstart_q, mstart_d;
  logic [1:0]              mmode_q, mmode_d;
  logic [DATA_WIDTH-1:0]   mtx_q, mtx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           idx_q, idx_d;

  logic                    win_found;
  logic [IW-1:0]           win_idx;
  logic [IW-1:0]           cand;
  logic [CW-1:0]           cnt_inc;
  logic                    tmo;

  // Round-robin search: the first requesting index at or after ptr+1, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((32'(ptr_q) + 32'(k)) % 32'(NUM_REQ));
      if (!win_found && Req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic. Every output is registered.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ack_d    = '0;
    err_d    = '0;
    rx_d     = rx_q;
    mstart_d = 1'b0;
    mmode_d  = mmode_q;
    mtx_d    = mtx_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    cnt_inc  = cnt_q + CW'(1);
    tmo      = (cnt_inc == CW'(TIMEOUT));
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d          = S_SETUP;
          idx_d            = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          mtx_d            = ReqTxData[win_idx*DATA_WIDTH +: DATA_WIDTH];
          mmode_d          = ReqMode[win_idx*2 +: 2];
        end
      end
      S_SETUP: begin
        state_d  = S_START;
        mstart_d = 1'b1;
      end
      S_START: begin
        state_d = S_WAIT_LOW;
        cnt_d   = '0;
      end
      S_WAIT_LOW: begin
        cnt_d = cnt_inc;
        // Timeout is checked first so that the counter can never wrap.
        if (tmo) begin
          state_d = S_IDLE;
          err_d   = grant_q;
          grant_d = '0;
          ptr_d   = idx_q;
        end else if (!MDone) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_inc;
        if (MDone) begin
          state_d = S_RESP;
          rx_d    = MRxData;
          ack_d   = grant_q;
        end else if (tmo) begin
          state_d = S_IDLE;
          err_d   = grant_q;
          grant_d = '0;
          ptr_d   = idx_q;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = idx_q;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers. Reset gives requester 0 first priority.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      rx_q     <= '0;
      busy_q   <= 1'b0;
      mstart_q <= 1'b0;
      mmode_q  <= '0;
      mtx_q    <= '0;
      cnt_q    <= '0;
      ptr_q    <= IW'(NUM_REQ - 1);
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rx_q     <= rx_d;
      busy_q   <= busy_d;
      mstart_q <= mstart_d;
      mmode_q  <= mmode_d;
      mtx_q    <= mtx_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
    end
  end

  assign Grant     = grant_q;
  assign Ack       = ack_q;
  assign Err       = err_q;
  assign RxData    = rx_q;
  assign Busy      = busy_q;
  assign MStart    = mstart_q;
  assign MMode     = mmode_q;
  assign MTxData   = mtx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter. A behavioural spi_master model serves the
// transfers. The scoreboard queues hold the expected Start and
// Ack/Err events in order.
`timescale 1ns/1ps
module tb_spi_master_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             Reset;
  logic [N-1:0]     Req;
  logic [N*W-1:0]   ReqTxData;
  logic [N*2-1:0]   ReqMode;
  logic [N-1:0]     Grant, Ack, Err;
  logic [W-1:0]     RxData;
  logic             Busy, MStart;
  logic [1:0]       MMode;
  logic [W-1:0]     MTxData;
  logic             MDone;
  logic [W-1:0]     MRxData;
  logic [2:0]       dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [11:0] start_exp_q[$];  // {idx, mode, tx}
  logic [10:0] ack_exp_q[$];    // {is_err, idx, rx}
  logic [W-1:0] slave_q[$];     // words the slave returns, in order
  logic [W-1:0] exp_last_rx;

  int          done_lat, drop_dly;
  bit          hang;
  bit          m_active;
  int          m_cnt, m_drop;
  logic [W-1:0] slave_got;
  logic [1:0]  got_mode;

  spi_master_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT(1023)) dut (
    .Clk(clk), .Reset(Reset), .Req(Req), .ReqTxData(ReqTxData), .ReqMode(ReqMode),
    .Grant(Grant), .Ack(Ack), .Err(Err), .RxData(RxData), .Busy(Busy),
    .MStart(MStart), .MMode(MMode), .MTxData(MTxData), .MDone(MDone),
    .MRxData(MRxData), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // spi_master model: Done is level-held; it falls drop_dly cycles after Start, then rises done_lat+1 cycles later
  always @(negedge clk) begin
    if (Reset) begin
      m_active = 1'b0;
      MDone    = 1'b1;
      MRxData  = '0;
    end else if (Err != '0) begin
      m_active = 1'b0;
    end else if (MStart === 1'b1) begin
      m_active  = 1'b1;
      m_drop    = drop_dly;
      m_cnt     = done_lat;
      slave_got = MTxData;
      got_mode  = MMode;
      if (drop_dly == 0) MDone = 1'b0;
    end else if (m_active) begin
      if (m_drop > 0) begin
        m_drop--;
        if (m_drop == 0) MDone = 1'b0;
      end else if (!hang) begin
        if (m_cnt > 0) m_cnt--;
        else begin
          MDone = 1'b1;
          if (slave_q.size() > 0) MRxData = slave_q.pop_front();
          else MRxData = '0;
          m_active = 1'b0;
        end
      end
    end
  end

  task automatic monitor_loop();
    logic [11:0] se;
    logic [10:0] ae;
    logic [N-1:0] eg, ea, ee;
    logic [N-1:0] prev_grant;
    logic [1:0]   prev_mode;
    logic [W-1:0] prev_tx;
    prev_grant = '0;
    prev_mode  = '0;
    prev_tx    = '0;
    forever begin
      @(negedge clk);
      if (Reset) exp_last_rx = '0;
      tests_run++;
      if (!$onehot0(Grant) || !$onehot0(Ack) || !$onehot0(Err)) begin
        tests_failed++;
        $display("FAIL onehot: grant=%b ack=%b err=%b expected at most one bit each", Grant, Ack, Err);
      end
      tests_run++;
      if ((int'(MStart) + int'(|Ack) + int'(|Err)) > 1) begin
        tests_failed++;
        $display("FAIL exclusive: mstart=%b ack=%b err=%b expected at most one active", MStart, Ack, Err);
      end
      if (prev_grant != '0 && Grant != '0) begin
        tests_run++;
        if (Grant !== prev_grant || MMode !== prev_mode || MTxData !== prev_tx) begin
          tests_failed++;
          $display("FAIL hold: grant=%b mode=%b tx=%h expected grant=%b mode=%b tx=%h",
                   Grant, MMode, MTxData, prev_grant, prev_mode, prev_tx);
        end
      end
      prev_grant = Grant;
      prev_mode  = MMode;
      prev_tx    = MTxData;
      if (MStart === 1'b1) begin
        tests_run++;
        if (start_exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL start_unexpected: got MStart with grant=%b expected none", Grant);
        end else begin
          se = start_exp_q.pop_front();
          eg = '0;
          eg[se[11:10]] = 1'b1;
          if (Grant !== eg || MMode !== se[9:8] || MTxData !== se[7:0]) begin
            tests_failed++;
            $display("FAIL start: grant=%b mode=%b tx=%h expected grant=%b mode=%b tx=%h",
                     Grant, MMode, MTxData, eg, se[9:8], se[7:0]);
          end
        end
      end
      if ((Ack | Err) != '0) begin
        tests_run++;
        if (ack_exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL resp_unexpected: ack=%b err=%b expected none", Ack, Err);
        end else begin
          ae = ack_exp_q.pop_front();
          eg = '0;
          eg[ae[9:8]] = 1'b1;
          ea = ae[10] ? '0 : eg;
          ee = ae[10] ? eg : '0;
          if (!ae[10]) exp_last_rx = ae[7:0];
          if (Ack !== ea || Err !== ee || RxData !== exp_last_rx) begin
            tests_failed++;
            $display("FAIL resp: ack=%b err=%b rx=%h expected ack=%b err=%b rx=%h",
                     Ack, Err, RxData, ea, ee, exp_last_rx);
          end
        end
      end
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] tx, input logic [1:0] mode);
    ReqTxData[i*W +: W] = tx;
    ReqMode[i*2 +: 2]   = mode;
  endtask

  task automatic push_txn(input logic [1:0] idx, input logic [W-1:0] tx, input logic [1:0] mode,
                          input logic [W-1:0] rx);
    start_exp_q.push_back({idx, mode, tx});
    ack_exp_q.push_back({1'b0, idx, rx});
    slave_q.push_back(rx);
  endtask

  task automatic push_err(input logic [1:0] idx, input logic [W-1:0] tx, input logic [1:0] mode);
    start_exp_q.push_back({idx, mode, tx});
    ack_exp_q.push_back({1'b1, idx, 8'h00});
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset    = 1'b1;
    Req      = '0;
    done_lat = 2;
    drop_dly = 0;
    hang     = 1'b0;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
  endtask

  // Wait for n Ack/Err pulses, dropping Req bits in drop_mask as each is served
  task automatic run_events(input int n, input logic [N-1:0] drop_mask, input int budget);
    int ev;
    int last;
    bit done;
    ev = 0;
    last = 0;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if ((Ack | Err) != '0) begin
        if (ev > 0) begin
          tests_run++;
          if (cyc - last < 2) begin
            tests_failed++;
            $display("FAIL resp_gap: got %0d cycles expected >= 2", cyc - last);
          end
        end
        last = cyc;
        ev++;
        Req = Req & ~((Ack | Err) & drop_mask);
        if (ev == n) begin
          Req  = '0;
          done = 1'b1;
        end
      end
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL run_timeout: got %0d responses expected %0d", ev, n);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (ack_exp_q.size() != 0 || start_exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d resp / %0d start pending expected 0",
               ack_exp_q.size(), start_exp_q.size());
    end
    ack_exp_q.delete();
    start_exp_q.delete();
    slave_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    tests_run += 9;
    if (Grant !== '0)   begin tests_failed++; $display("FAIL rst_grant: got %b expected 0", Grant); end
    if (Ack !== '0)     begin tests_failed++; $display("FAIL rst_ack: got %b expected 0", Ack); end
    if (Err !== '0)     begin tests_failed++; $display("FAIL rst_err: got %b expected 0", Err); end
    if (MStart !== 1'b0) begin tests_failed++; $display("FAIL rst_mstart: got %b expected 0", MStart); end
    if (Busy !== 1'b0)  begin tests_failed++; $display("FAIL rst_busy: got %b expected 0", Busy); end
    if (MMode !== 2'b00) begin tests_failed++; $display("FAIL rst_mmode: got %b expected 0", MMode); end
    if (MTxData !== '0) begin tests_failed++; $display("FAIL rst_mtx: got %h expected 0", MTxData); end
    if (RxData !== '0)  begin tests_failed++; $display("FAIL rst_rx: got %h expected 0", RxData); end
    if (dbg_state !== 3'd0) begin tests_failed++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_single();
    int s;
    bit found;
    do_reset();
    set_req(0, 8'hA5, 2'b00);
    push_txn(2'd0, 8'hA5, 2'b00, 8'hD6);
    Req = 4'b0001;
    @(negedge clk);
    tests_run += 2;
    if (Grant !== 4'b0001) begin tests_failed++; $display("FAIL single_grant: got %b expected 0001", Grant); end
    if (MStart !== 1'b0) begin tests_failed++; $display("FAIL single_setup_mstart: got %b expected 0", MStart); end
    @(negedge clk);
    s = cyc;
    tests_run++;
    if (MStart !== 1'b1) begin tests_failed++; $display("FAIL single_mstart: got %b expected 1", MStart); end
    @(negedge clk);
    tests_run++;
    if (MStart !== 1'b0) begin tests_failed++; $display("FAIL single_mstart_len: got %b expected 0", MStart); end
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (Ack[0] === 1'b1) begin
        found = 1'b1;
        Req = '0;
        tests_run += 3;
        if (cyc - s != 4) begin tests_failed++; $display("FAIL single_latency: got %0d expected 4", cyc - s); end
        if (slave_got !== 8'hA5) begin tests_failed++; $display("FAIL single_slave_rx: got %h expected a5", slave_got); end
        if (RxData !== 8'hD6) begin tests_failed++; $display("FAIL single_rx: got %h expected d6", RxData); end
      end
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("FAIL single_timeout: got no ack expected ack"); Req = '0; end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_multi();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h11 * (i + 1)), 2'b00);
    push_txn(2'd0, 8'h11, 2'b00, 8'h81);
    push_txn(2'd1, 8'h22, 2'b00, 8'h82);
    push_txn(2'd2, 8'h33, 2'b00, 8'h83);
    push_txn(2'd3, 8'h44, 2'b00, 8'h84);
    push_txn(2'd0, 8'h11, 2'b00, 8'h85);
    Req = 4'b1111;
    run_events(5, 4'b0000, 400);
  endtask

  task automatic test_modes();
    do_reset();
    set_req(1, 8'h96, 2'b11);
    set_req(2, 8'h69, 2'b01);
    push_txn(2'd1, 8'h96, 2'b11, 8'h4B);
    push_txn(2'd2, 8'h69, 2'b01, 8'hB4);
    Req = 4'b0110;
    run_events(2, 4'b1111, 200);
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(3, 8'hE7, 2'b10);
    push_txn(2'd3, 8'hE7, 2'b10, 8'h01);
    push_txn(2'd3, 8'hE7, 2'b10, 8'h02);
    push_txn(2'd3, 8'hE7, 2'b10, 8'h03);
    Req = 4'b1000;
    run_events(3, 4'b0000, 300);
  endtask

  task automatic test_req_drop();
    do_reset();
    set_req(0, 8'h5C, 2'b00);
    set_req(1, 8'hC5, 2'b00);
    push_txn(2'd0, 8'h5C, 2'b00, 8'h77);
    Req = 4'b0011;
    @(negedge clk);
    tests_run++;
    if (Grant !== 4'b0001) begin tests_failed++; $display("FAIL drop_grant: got %b expected 0001", Grant); end
    Req = 4'b0000;
    run_events(1, 4'b1111, 100);
    repeat (6) @(negedge clk);
    tests_run += 2;
    if (Busy !== 1'b0) begin tests_failed++; $display("FAIL drop_busy: got %b expected 0", Busy); end
    if (Grant !== '0) begin tests_failed++; $display("FAIL drop_idle_grant: got %b expected 0", Grant); end
  endtask

  task automatic test_stale_done();
    int s;
    bit found;
    do_reset();
    set_req(0, 8'h5A, 2'b00);
    push_txn(2'd0, 8'h5A, 2'b00, 8'h44);
    Req = 4'b0001;
    run_events(1, 4'b1111, 100);
    drop_dly = 3;
    done_lat = 1;
    set_req(1, 8'hA5, 2'b00);
    push_txn(2'd1, 8'hA5, 2'b00, 8'hBB);
    Req = 4'b0010;
    s = 0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (MStart === 1'b1) begin s = cyc; found = 1'b1; end
    end
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (Ack != '0) begin
        found = 1'b1;
        Req = '0;
        tests_run += 2;
        if (cyc - s != 6) begin tests_failed++; $display("FAIL stale_latency: got %0d expected 6", cyc - s); end
        if (RxData !== 8'hBB) begin tests_failed++; $display("FAIL stale_rx: got %h expected bb", RxData); end
      end
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("FAIL stale_timeout: got no ack expected ack"); Req = '0; end
    repeat (4) @(negedge clk);
    ack_exp_q.delete();
    start_exp_q.delete();
    slave_q.delete();
  endtask

  task automatic test_timeout();
    int s;
    bit found;
    do_reset();
    set_req(0, 8'h3C, 2'b00);
    push_txn(2'd0, 8'h3C, 2'b00, 8'h9E);
    Req = 4'b0001;
    run_events(1, 4'b1111, 100);
    hang = 1'b1;
    set_req(1, 8'hF0, 2'b10);
    set_req(2, 8'h0F, 2'b01);
    push_err(2'd1, 8'hF0, 2'b10);
    push_txn(2'd2, 8'h0F, 2'b01, 8'h6D);
    Req = 4'b0110;
    s = 0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (MStart === 1'b1) begin s = cyc; found = 1'b1; end
    end
    found = 1'b0;
    for (int k = 0; k < 1100 && !found; k++) begin
      @(negedge clk);
      if (Err != '0) begin
        found = 1'b1;
        hang = 1'b0;
        Req[1] = 1'b0;
        tests_run += 3;
        if (cyc - s != 1024) begin tests_failed++; $display("FAIL tmo_latency: got %0d expected 1024", cyc - s); end
        if (Err !== 4'b0010) begin tests_failed++; $display("FAIL tmo_err: got %b expected 0010", Err); end
        if (RxData !== 8'h9E) begin tests_failed++; $display("FAIL tmo_rx_hold: got %h expected 9e", RxData); end
      end
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("FAIL tmo_timeout: got no err expected err"); hang = 1'b0; end
    run_events(1, 4'b1111, 200);
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    set_req(1, 8'h21, 2'b00);
    push_txn(2'd1, 8'h21, 2'b00, 8'h5E);
    Req = 4'b0010;
    run_events(1, 4'b1111, 100);
    done_lat = 20;
    set_req(2, 8'hAB, 2'b00);
    start_exp_q.push_back({2'd2, 2'b00, 8'hAB});
    Req = 4'b0100;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (MStart === 1'b1) found = 1'b1;
    end
    repeat (5) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    tests_run += 9;
    if (dbg_state !== 3'd0) begin tests_failed++; $display("FAIL mid_state: got %0d expected 0", dbg_state); end
    if (Grant !== '0)   begin tests_failed++; $display("FAIL mid_grant: got %b expected 0", Grant); end
    if (Ack !== '0)     begin tests_failed++; $display("FAIL mid_ack: got %b expected 0", Ack); end
    if (Err !== '0)     begin tests_failed++; $display("FAIL mid_err: got %b expected 0", Err); end
    if (MStart !== 1'b0) begin tests_failed++; $display("FAIL mid_mstart: got %b expected 0", MStart); end
    if (Busy !== 1'b0)  begin tests_failed++; $display("FAIL mid_busy: got %b expected 0", Busy); end
    if (MMode !== 2'b00) begin tests_failed++; $display("FAIL mid_mmode: got %b expected 0", MMode); end
    if (MTxData !== '0) begin tests_failed++; $display("FAIL mid_mtx: got %h expected 0", MTxData); end
    if (RxData !== '0)  begin tests_failed++; $display("FAIL mid_rx: got %h expected 0", RxData); end
    @(negedge clk);
    Reset = 1'b0;
    done_lat = 2;
    set_req(0, 8'h12, 2'b01);
    push_txn(2'd0, 8'h12, 2'b01, 8'hC8);
    push_txn(2'd2, 8'hAB, 2'b00, 8'h8C);
    Req = 4'b0101;
    run_events(2, 4'b1111, 200);
  endtask

  initial begin
    Reset     = 1'b1;
    Req       = '0;
    ReqTxData = '0;
    ReqMode   = '0;
    done_lat  = 2;
    drop_dly  = 0;
    hang      = 1'b0;
    exp_last_rx = '0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_single();
    test_multi();
    test_modes();
    test_back_to_back();
    test_req_drop();
    test_stale_done();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one spi_master.
REQ-002 Parameter DATA_WIDTH, default 8: SPI word width; matches spi_master DATA_WIDTH.
REQ-003 Parameter TIMEOUT, default 1023: maximum cycles from MStart to MDone before the transaction is aborted.
REQ-004 Clk  in  1  single clock; all logic on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Req  in  NUM_REQ  per-requester request level; held high until that requester's Ack or Err.
REQ-007 ReqTxData  in  NUM_REQ*DATA_WIDTH  per-requester transmit word; slice i belongs to requester i.
REQ-008 ReqMode  in  NUM_REQ*2  per-requester SPI mode (CPOL,CPHA); slice i belongs to requester i.
REQ-009 Grant  out  NUM_REQ  one-hot owner of the master; all zero when idle.
REQ-010 Ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-011 Err  out  NUM_REQ  one-cycle timeout pulse to the granted requester.
REQ-012 RxData  out  DATA_WIDTH  last received word; valid in the Ack cycle and held until the next Ack.
REQ-013 Busy  out  1  high in every state except IDLE.
REQ-014 MStart  out  1  Start pulse to spi_master.
REQ-015 MMode  out  2  MODE to spi_master.
REQ-016 MTxData  out  DATA_WIDTH  TxData to spi_master.
REQ-017 MDone  in  1  Done from spi_master.
REQ-018 MRxData  in  DATA_WIDTH  RxData from spi_master.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, START, WAIT_LOW, WAIT_DONE and RESP.
REQ-020 In IDLE with any Req bit high, the block SHALL pick the winner by round robin, searching upward from (last granted + 1) mod NUM_REQ, and enter SETUP.
REQ-021 On entering SETUP, the block SHALL register the winner's ReqTxData into MTxData, its ReqMode into MMode and its one-hot index into Grant.
REQ-022 MMode and MTxData SHALL stay constant from SETUP until the return to IDLE, so the mode is settled one cycle before Start.
REQ-023 The block SHALL go SETUP -> START unconditionally; MStart SHALL be high for exactly the one START cycle.
REQ-024 The block SHALL go START -> WAIT_LOW unconditionally.
REQ-025 In WAIT_LOW, MDone==0 SHALL cause a move to WAIT_DONE, which tolerates a level-held Done left over from the previous transfer.
REQ-026 In WAIT_DONE, MDone==1 SHALL capture MRxData into RxData and cause a move to RESP.
REQ-027 In RESP, Ack[grant] SHALL be 1 for one cycle; on the next cycle Grant SHALL clear, the pointer SHALL update to the grant index, and the FSM SHALL return to IDLE.
REQ-028 Latency, from Req sampled in IDLE at cycle n: Grant at n+1, MStart at n+2, and Ack 1 cycle after the MDone sample.
REQ-029 Between Acks there SHALL be at least one IDLE cycle.
REQ-030 A timeout counter SHALL clear in START and increment each cycle in WAIT_LOW or WAIT_DONE.
REQ-031 When the counter reaches TIMEOUT, Err[grant] SHALL pulse for one cycle instead of Ack, RxData SHALL stay unchanged, the pointer SHALL advance, and the FSM SHALL return to IDLE.
REQ-032 A Req drop after grant SHALL be ignored: the transfer completes and Ack still pulses.
REQ-033 A Req drop before grant SHALL mean no service for that requester.
REQ-034 Req changes during a transaction SHALL NOT affect MMode, MTxData or Grant.
REQ-035 Ack, Err and MStart SHALL never be high in the same cycle; at most one bit of Grant, Ack or Err SHALL be high.
REQ-036 With a single requester holding Req continuously, the block SHALL serve it back-to-back.
REQ-037 Pointer wrap SHALL be modulo NUM_REQ.

Reset
REQ-038 Reset SHALL put the FSM in IDLE and set Grant, Ack, Err, MStart, Busy, MMode, MTxData, RxData and the timeout counter to 0.
REQ-039 Reset SHALL set the pointer to NUM_REQ-1, so requester 0 has first priority.
REQ-040 Reset mid-transaction SHALL abort on the next edge with no Ack or Err; the spi_master shares the Reset line.

Verification
REQ-041 Req=4'b0001, ReqTxData[7:0]=8'hA5, slave TxData=8'hD6, mode 0 -> Grant=0001 at n+1, one-cycle MStart at n+2, then Ack[0] with RxData=8'hD6; slave receives 8'hA5.
REQ-042 Req=4'b1111 held, distinct data per requester -> Acks in order 0,1,2,3,0; each RxData matches its slave word; never two Grant bits high.
REQ-043 Requester 1 uses mode 2'b11 and requester 2 uses 2'b01, back-to-back -> MMode changes only in SETUP and is stable through MStart; both transfers correct.
REQ-044 MDone forced to 0 (model hung), TIMEOUT=1023 -> Err[g] exactly 1024 cycles after MStart; RxData unchanged; next requester then served.
REQ-045 Reset asserted in WAIT_DONE -> next cycle state IDLE, all outputs 0, no Ack or Err; the next request goes to requester 0 first.
REQ-046 MDone held high before Start -> no completion until MDone falls and rises again; Ack only after the real transfer.
